// File: rtl/bf16_skew_feeder.sv
// Stages one K-deep tile of BF16 row operands, then replays it into the array's
// west edge with a one-cycle-per-row diagonal skew.
module bf16_skew_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ROWS       = 4,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    input  logic                       out_en,
    output logic [ROWS*DATA_WIDTH-1:0] a_out,
    output logic [ROWS-1:0]            a_valid,
    output logic                       busy,
    output logic                       tile_done
);

    // state   | meaning
    // S_LOAD  | accepting beats into the tile buffer
    // S_FEED  | replaying skewed operands, one step per enabled cycle
    // S_DONE  | one-cycle wrap-up: clear outputs, pulse tile_done
    typedef enum logic [1:0] {S_LOAD, S_FEED, S_DONE} state_t;

    localparam int KW     = $clog2(DEPTH);
    localparam int TW     = $clog2(DEPTH + ROWS);
    localparam int LAST_T = DEPTH + ROWS - 2;

    state_t                     state_q, state_d;
    logic [KW-1:0]              wr_k_q, wr_k_d;
    logic [TW-1:0]              t_q, t_d;
    logic [ROWS*DATA_WIDTH-1:0] a_out_q, a_out_d;
    logic [ROWS-1:0]            a_valid_q, a_valid_d;
    logic                       in_ready_q, busy_q, tile_done_q;
    logic                       wr_en;
    logic [ROWS*DATA_WIDTH-1:0] tile_q [DEPTH];

    always_comb begin
        state_d   = state_q;
        wr_k_d    = wr_k_q;
        t_d       = t_q;
        a_out_d   = a_out_q;
        a_valid_d = a_valid_q;
        wr_en     = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    wr_en = 1'b1;
                    if (wr_k_q == KW'(DEPTH - 1)) begin
                        state_d = S_FEED;
                        wr_k_d  = '0;
                        t_d     = '0;
                    end else begin
                        wr_k_d = wr_k_q + KW'(1);
                    end
                end
            end
            S_FEED: begin
                if (out_en) begin
                    // Row r reads buffer entry t-r; outside that window it idles at zero.
                    for (int r = 0; r < ROWS; r++) begin
                        a_out_d[r*DATA_WIDTH +: DATA_WIDTH] = '0;
                        a_valid_d[r]                        = 1'b0;
                        for (int k = 0; k < DEPTH; k++) begin
                            if (int'(t_q) == k + r) begin
                                a_out_d[r*DATA_WIDTH +: DATA_WIDTH] = tile_q[k][r*DATA_WIDTH +: DATA_WIDTH];
                                a_valid_d[r]                        = 1'b1;
                            end
                        end
                    end
                    t_d = t_q + TW'(1);
                    if (t_q == TW'(LAST_T)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                a_out_d   = '0;
                a_valid_d = '0;
                t_d       = '0;
                state_d   = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD;
            wr_k_q      <= '0;
            t_q         <= '0;
            a_out_q     <= '0;
            a_valid_q   <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_k_q      <= wr_k_d;
            t_q         <= t_d;
            a_out_q     <= a_out_d;
            a_valid_q   <= a_valid_d;
            in_ready_q  <= (state_d == S_LOAD);
            busy_q      <= (state_d != S_LOAD);
            tile_done_q <= (state_d == S_DONE);
        end
    end

    // Buffer is fully rewritten by every LOAD before it is read, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tile_q[wr_k_q] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign a_out     = a_out_q;
    assign a_valid   = a_valid_q;
    assign busy      = busy_q;
    assign tile_done = tile_done_q;

endmodule
